// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants and FSM state type for the interval-timer
//               bus initiator (timer_master).
//               - Register word addresses of the 16-bit interval-timer slave.
//               - Control-register bit indices.
//               - The initiator FSM state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    // Slave register word addresses
    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;
    localparam logic [2:0] TMR_SNAPL   = 3'd4;
    localparam logic [2:0] TMR_SNAPH   = 3'd5;

    // Control register bit positions
    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    // Initiator FSM states; every state except IDLE, RB_CHK and SNAP_DONE
    // issues exactly one bus cycle.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_PL     = 4'd1,
        ST_WR_PH     = 4'd2,
        ST_RB_L      = 4'd3,
        ST_RB_H      = 4'd4,
        ST_RB_CHK    = 4'd5,
        ST_WR_CTRL   = 4'd6,
        ST_STOP      = 4'd7,
        ST_CLR_ST    = 4'd8,
        ST_SNAP_W    = 4'd9,
        ST_SNAP_RL   = 4'd10,
        ST_SNAP_RH   = 4'd11,
        ST_SNAP_DONE = 4'd12
    } tmr_state_t;

endpackage : timer_pkg

`default_nettype wire

// File: rtl/timer_master.sv
// ============================================================================
// Module      : timer_master
// Description : Avalon-MM initiator for a 16-bit interval-timer slave.
//               Converts user requests (configure/start, stop, snapshot) and
//               the timer irq into register write/read sequences.
// Revision    : 1.0 - initial release
//
// Parameters  : CTRL_ITO     - value of control bit0 (irq enable) on start
//               SNAP_ON_TICK - 1: take a snapshot after every serviced timeout
//
// Ports       : clk, reset_n          - clock, async active-low reset
//               address/chipselect/write_n/writedata/readdata/irq
//                                      - timer slave bus (registered outputs)
//               cfg_valid/cfg_ready/cfg_period/cfg_continuous
//                                      - configure/start handshake
//               stop_req, snap_req     - single-cycle request pulses
//               snap_valid, snap_value - snapshot result
//               tick                   - one pulse per serviced timeout
//               busy                   - FSM not idle
//               cfg_error              - period readback mismatch (macro only)
//
// Build macro : TIMER_MASTER_READBACK_EN - read the period back after writing
//               it, and only start the timer when both halves match.
// ============================================================================
`default_nettype none

module timer_master
    import timer_pkg::*;
#(
    parameter bit CTRL_ITO     = 1'b1,
    parameter bit SNAP_ON_TICK = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    input  logic        irq,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_period,
    input  logic        cfg_continuous,
    input  logic        stop_req,
    input  logic        snap_req,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic        tick,
    output logic        busy
`ifdef TIMER_MASTER_READBACK_EN
    ,
    output logic        cfg_error
`endif
);

    tmr_state_t  r_state;
    tmr_state_t  w_next;
    logic [31:0] r_period;
    logic        r_cont;
    logic        r_stop_pend;
    logic        r_snap_pend;
    logic        w_handshake;

    logic        w_cs;
    logic        w_wn;
    logic [2:0]  w_addr;
    logic [15:0] w_wdata;

`ifdef TIMER_MASTER_READBACK_EN
    logic        r_rb_lo_bad;
    logic        w_rb_bad;

    // Low-half verdict was registered in RB_H; high half is on readdata now.
    assign w_rb_bad = r_rb_lo_bad | (readdata != r_period[31:16]);
`endif

    assign cfg_ready   = (r_state == ST_IDLE) & ~irq & ~r_stop_pend;
    assign w_handshake = cfg_valid & cfg_ready;
    assign busy        = (r_state != ST_IDLE);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin : p_next
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (irq)              w_next = ST_CLR_ST;
                else if (r_stop_pend) w_next = ST_STOP;
                else if (w_handshake) w_next = ST_WR_PL;
                else if (r_snap_pend) w_next = ST_SNAP_W;
            end
            ST_WR_PL:     w_next = ST_WR_PH;
`ifdef TIMER_MASTER_READBACK_EN
            ST_WR_PH:     w_next = ST_RB_L;
            ST_RB_L:      w_next = ST_RB_H;
            ST_RB_H:      w_next = ST_RB_CHK;
            ST_RB_CHK:    w_next = w_rb_bad ? ST_IDLE : ST_WR_CTRL;
`else
            ST_WR_PH:     w_next = ST_WR_CTRL;
`endif
            ST_WR_CTRL:   w_next = ST_IDLE;
            ST_STOP:      w_next = ST_IDLE;
            ST_CLR_ST:    w_next = SNAP_ON_TICK ? ST_SNAP_W : ST_IDLE;
            ST_SNAP_W:    w_next = ST_SNAP_RL;
            ST_SNAP_RL:   w_next = ST_SNAP_RH;
            ST_SNAP_RH:   w_next = ST_SNAP_DONE;
            ST_SNAP_DONE: w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Bus cycle decode. Decoding the state being entered lets the bus
    // outputs be registered while still lining up with the state cycle.
    // WR_PL is only entered on the handshake edge, before r_period has been
    // loaded, so its data comes straight from cfg_period.
    // ------------------------------------------------------------------------
    always_comb begin : p_bus
        w_cs    = 1'b0;
        w_wn    = 1'b1;
        w_addr  = TMR_STATUS;
        w_wdata = 16'h0000;
        case (w_next)
            ST_WR_PL: begin
                w_cs    = 1'b1;
                w_wn    = 1'b0;
                w_addr  = TMR_PERIODL;
                w_wdata = cfg_period[15:0];
            end
            ST_WR_PH: begin
                w_cs    = 1'b1;
                w_wn    = 1'b0;
                w_addr  = TMR_PERIODH;
                w_wdata = r_period[31:16];
            end
            ST_RB_L: begin
                w_cs   = 1'b1;
                w_addr = TMR_PERIODL;
            end
            ST_RB_H: begin
                w_cs   = 1'b1;
                w_addr = TMR_PERIODH;
            end
            ST_WR_CTRL: begin
                w_cs           = 1'b1;
                w_wn           = 1'b0;
                w_addr         = TMR_CONTROL;
                w_wdata[ITO]   = CTRL_ITO;
                w_wdata[CONT]  = r_cont;
                w_wdata[START] = 1'b1;
            end
            ST_STOP: begin
                w_cs          = 1'b1;
                w_wn          = 1'b0;
                w_addr        = TMR_CONTROL;
                w_wdata[STOP] = 1'b1;
            end
            ST_CLR_ST: begin
                w_cs   = 1'b1;
                w_wn   = 1'b0;
                w_addr = TMR_STATUS;
            end
            ST_SNAP_W: begin
                w_cs   = 1'b1;
                w_wn   = 1'b0;
                w_addr = TMR_SNAPL;
            end
            ST_SNAP_RL: begin
                w_cs   = 1'b1;
                w_addr = TMR_SNAPL;
            end
            ST_SNAP_RH: begin
                w_cs   = 1'b1;
                w_addr = TMR_SNAPH;
            end
            default: begin
                w_cs = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, bus and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin : p_regs
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            chipselect  <= 1'b0;
            write_n     <= 1'b1;
            address     <= 3'd0;
            writedata   <= 16'h0000;
            tick        <= 1'b0;
            r_period    <= 32'h0000_0000;
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_snap_pend <= 1'b0;
            snap_valid  <= 1'b0;
            snap_value  <= 32'h0000_0000;
        end else begin
            r_state    <= w_next;
            chipselect <= w_cs;
            write_n    <= w_wn;
            address    <= w_addr;
            writedata  <= w_wdata;
            // CLR_ST lasts one cycle, so tick pulses with the status write.
            tick       <= (w_next == ST_CLR_ST);

            if (w_handshake) begin
                r_period <= cfg_period;
                r_cont   <= cfg_continuous;
            end

            // A new request wins over the clear on the start cycle, so a
            // request arriving during a running sequence gives one more run.
            r_stop_pend <= (r_stop_pend & (w_next != ST_STOP)) | stop_req;
            r_snap_pend <= (r_snap_pend & (w_next != ST_SNAP_W)) | snap_req;

            // Readdata lags the read address by one cycle.
            if (r_state == ST_SNAP_RH)
                snap_value[15:0] <= readdata;
            if (r_state == ST_SNAP_DONE)
                snap_value[31:16] <= readdata;
            snap_valid <= (r_state == ST_SNAP_DONE);
        end
    end

`ifdef TIMER_MASTER_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin : p_readback
        if (!reset_n) begin
            r_rb_lo_bad <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            if (r_state == ST_RB_H)
                r_rb_lo_bad <= (readdata != r_period[15:0]);
            if (w_handshake)
                cfg_error <= 1'b0;
            else if ((r_state == ST_RB_CHK) && w_rb_bad)
                cfg_error <= 1'b1;
        end
    end
`endif

endmodule : timer_master

`default_nettype wire

// File: tb/tb_timer_master.sv
// ============================================================================
// Module      : tb_timer_master
// Description : Directed self-checking bench for timer_master with a small
//               interval-timer slave model (registers, snapshot source, irq).
//               Build with TIMER_MASTER_READBACK_EN to exercise cfg_error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_master;

`ifdef TIMER_MASTER_READBACK_EN
    localparam int CFG_LAT = 6;
`else
    localparam int CFG_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = 32'h0;
    logic        cfg_continuous = 1'b0;
    logic        stop_req = 1'b0;
    logic        snap_req = 1'b0;
    logic        snap_valid;
    logic [31:0] snap_value;
    logic        tick;
    logic        busy;
`ifdef TIMER_MASTER_READBACK_EN
    logic        cfg_error;
`endif

    // slave model controls
    logic        raise_irq = 1'b0;
    logic        corrupt   = 1'b0;
    logic [31:0] snap_src  = 32'h0;
    logic [15:0] regs [0:7];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic        wn;
        logic [2:0]  a;
        logic [15:0] d;
    } acc_t;

    acc_t wlog[$];
    acc_t alog[$];
    int   tick_cnt = 0, last_tick_cyc = -1;
    int   snapv_cnt = 0, last_snapv_cyc = -1;
    logic [31:0] last_snapv_val = 32'h0;
    int   busy_cnt = 0;

    timer_master #(.CTRL_ITO(1'b1), .SNAP_ON_TICK(1'b0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .irq            (irq),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .stop_req       (stop_req),
        .snap_req       (snap_req),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .tick           (tick),
        .busy           (busy)
`ifdef TIMER_MASTER_READBACK_EN
        ,
        .cfg_error      (cfg_error)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Interval-timer slave model
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
            readdata <= 16'h0;
            irq      <= 1'b0;
        end else begin
            if (chipselect && write_n)
                readdata <= (address == 3'd3 && corrupt) ? (regs[3] ^ 16'h0100) : regs[address];
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: ;
                    3'd4: begin
                        regs[4] <= snap_src[15:0];
                        regs[5] <= snap_src[31:16];
                    end
                    default: regs[address] <= writedata;
                endcase
            end
            if (chipselect && !write_n && address == 3'd0) irq <= 1'b0;
            else if (raise_irq)                             irq <= 1'b1;
        end
    end

    // Bus / pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        acc_t e;
        if (reset_n && chipselect) begin
            e.cyc = cyc; e.wn = write_n; e.a = address; e.d = writedata;
            alog.push_back(e);
            if (!write_n) wlog.push_back(e);
        end
        if (tick) begin tick_cnt++; last_tick_cyc = cyc; end
        if (snap_valid) begin snapv_cnt++; last_snapv_cyc = cyc; last_snapv_val = snap_value; end
        if (busy) busy_cnt++;
    end

    // Advance n cycles; inputs change 1 ns after the falling edge
    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic clear_logs();
        wlog.delete(); alog.delete();
        tick_cnt = 0; snapv_cnt = 0; busy_cnt = 0;
        last_tick_cyc = -1; last_snapv_cyc = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(3);
        n_checks++; if (chipselect !== 1'b0) $display("FAIL rst_cs: got %h want 0", chipselect); else n_pass++;
        n_checks++; if (write_n !== 1'b1) $display("FAIL rst_write_n: got %h want 1", write_n); else n_pass++;
        n_checks++; if ({address, writedata} !== 19'h0) $display("FAIL rst_addr_data: got %h/%h want 0/0", address, writedata); else n_pass++;
        n_checks++; if ({snap_value, snap_valid, tick, busy} !== 35'h0) $display("FAIL rst_status: got val=%h sv=%b tick=%b busy=%b want 0", snap_value, snap_valid, tick, busy); else n_pass++;
        n_checks++; if (cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready: got %h want 1", cfg_ready); else n_pass++;
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_configure();
        clear_logs();
        cfg_valid = 1'b1; cfg_period = 32'h0001_86A0; cfg_continuous = 1'b1;
        n_checks++; if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_idle: got %h want 1", cfg_ready); else n_pass++;
        step(1);
        cfg_valid = 1'b0;
        step(CFG_LAT + 3);
        n_checks++; if (wlog.size() !== 3) $display("FAIL cfg_nwrites: got %0d want 3", wlog.size()); else n_pass++;
        if (wlog.size() == 3) begin
            n_checks++; if ({wlog[0].a, wlog[0].d} !== {3'd2, 16'h86A0}) $display("FAIL cfg_wr0: got %h/%h want 2/86a0", wlog[0].a, wlog[0].d); else n_pass++;
            n_checks++; if ({wlog[1].a, wlog[1].d} !== {3'd3, 16'h0001}) $display("FAIL cfg_wr1: got %h/%h want 3/0001", wlog[1].a, wlog[1].d); else n_pass++;
            n_checks++; if ({wlog[2].a, wlog[2].d} !== {3'd1, 16'h0007}) $display("FAIL cfg_wr2: got %h/%h want 1/0007", wlog[2].a, wlog[2].d); else n_pass++;
            n_checks++; if (wlog[2].cyc - wlog[0].cyc !== CFG_LAT - 1) $display("FAIL cfg_spacing: got %0d want %0d", wlog[2].cyc - wlog[0].cyc, CFG_LAT - 1); else n_pass++;
        end
        n_checks++; if (busy_cnt !== CFG_LAT) $display("FAIL cfg_busy_cycles: got %0d want %0d", busy_cnt, CFG_LAT); else n_pass++;

        // period 0 and one-shot mode
        clear_logs();
        cfg_valid = 1'b1; cfg_period = 32'h0; cfg_continuous = 1'b0;
        step(1);
        cfg_valid = 1'b0;
        step(CFG_LAT + 3);
        n_checks++; if (wlog.size() !== 3) $display("FAIL cfg0_nwrites: got %0d want 3", wlog.size()); else n_pass++;
        if (wlog.size() == 3) begin
            n_checks++; if ({wlog[0].d, wlog[1].d, wlog[2].a, wlog[2].d} !== {16'h0, 16'h0, 3'd1, 16'h0005}) $display("FAIL cfg0_data: got %h %h %h/%h want 0 0 1/0005", wlog[0].d, wlog[1].d, wlog[2].a, wlog[2].d); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        raise_irq = 1'b1;
        step(1);
        raise_irq = 1'b0;
        step(6);
        n_checks++; if (wlog.size() !== 1) $display("FAIL to_nwrites: got %0d want 1", wlog.size()); else n_pass++;
        if (wlog.size() == 1) begin
            n_checks++; if ({wlog[0].a, wlog[0].d} !== {3'd0, 16'h0000}) $display("FAIL to_wr: got %h/%h want 0/0000", wlog[0].a, wlog[0].d); else n_pass++;
            n_checks++; if (last_tick_cyc !== wlog[0].cyc) $display("FAIL to_tick_align: got cyc %0d want %0d", last_tick_cyc, wlog[0].cyc); else n_pass++;
        end
        n_checks++; if (tick_cnt !== 1) $display("FAIL to_tick_count: got %0d want 1", tick_cnt); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL to_irq_cleared: got %h want 0", irq); else n_pass++;
    endtask

    task automatic test_snapshot();
        clear_logs();
        snap_src = 32'h1234_5678;
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        step(8);
        n_checks++; if (alog.size() !== 3) $display("FAIL snap_naccess: got %0d want 3", alog.size()); else n_pass++;
        if (alog.size() == 3) begin
            n_checks++; if ({alog[0].wn, alog[0].a, alog[1].wn, alog[1].a, alog[2].wn, alog[2].a} !== {1'b0, 3'd4, 1'b1, 3'd4, 1'b1, 3'd5})
                $display("FAIL snap_seq: got %b%h %b%h %b%h want 04 14 15", alog[0].wn, alog[0].a, alog[1].wn, alog[1].a, alog[2].wn, alog[2].a); else n_pass++;
            n_checks++; if (last_snapv_cyc !== alog[0].cyc + 4) $display("FAIL snap_latency: got %0d want %0d", last_snapv_cyc - alog[0].cyc, 4); else n_pass++;
        end
        n_checks++; if (snapv_cnt !== 1) $display("FAIL snap_valid_count: got %0d want 1", snapv_cnt); else n_pass++;
        n_checks++; if (last_snapv_val !== 32'h1234_5678) $display("FAIL snap_value: got %h want 12345678", last_snapv_val); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_logs();
        snap_src = 32'hCAFE_F00D;
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        step(2);
        snap_req = 1'b1;          // lands while the first snapshot runs
        step(1);
        snap_req = 1'b0;
        snap_src = 32'h0BAD_BEEF; // first snapshot already latched
        step(14);
        n_checks++; if (alog.size() !== 6) $display("FAIL b2b_naccess: got %0d want 6", alog.size()); else n_pass++;
        n_checks++; if (snapv_cnt !== 2) $display("FAIL b2b_valid_count: got %0d want 2", snapv_cnt); else n_pass++;
        n_checks++; if (snap_value !== 32'h0BAD_BEEF) $display("FAIL b2b_value: got %h want 0badbeef", snap_value); else n_pass++;
    endtask

    task automatic test_priority();
        bit got = 0;
        clear_logs();
        raise_irq = 1'b1;
        step(1);
        raise_irq = 1'b0;
        stop_req = 1'b1; cfg_valid = 1'b1; cfg_period = 32'h0002_0003; cfg_continuous = 1'b1;
        n_checks++; if (cfg_ready !== 1'b0) $display("FAIL pri_ready_low: got %h want 0", cfg_ready); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step(1);
            stop_req = 1'b0;
            if (cfg_ready) begin
                n_checks++; if (wlog.size() !== 2 || tick_cnt !== 1) $display("FAIL pri_ready_early: got writes=%0d ticks=%0d want 2/1", wlog.size(), tick_cnt); else n_pass++;
                step(1);
                cfg_valid = 1'b0;
                got = 1;
                break;
            end
        end
        cfg_valid = 1'b0;
        n_checks++; if (!got) $display("FAIL pri_handshake: got none want handshake within 20 cycles"); else n_pass++;
        step(CFG_LAT + 3);
        n_checks++; if (wlog.size() !== 5) $display("FAIL pri_nwrites: got %0d want 5", wlog.size()); else n_pass++;
        if (wlog.size() == 5) begin
            n_checks++; if ({wlog[0].a, wlog[0].d, wlog[1].a, wlog[1].d} !== {3'd0, 16'h0000, 3'd1, 16'h0008}) $display("FAIL pri_order: got %h/%h %h/%h want 0/0000 1/0008", wlog[0].a, wlog[0].d, wlog[1].a, wlog[1].d); else n_pass++;
            n_checks++; if ({wlog[2].d, wlog[3].d, wlog[4].a, wlog[4].d} !== {16'h0003, 16'h0002, 3'd1, 16'h0007}) $display("FAIL pri_cfg: got %h %h %h/%h want 0003 0002 1/0007", wlog[2].d, wlog[3].d, wlog[4].a, wlog[4].d); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        cfg_valid = 1'b1; cfg_period = 32'h0000_1111; cfg_continuous = 1'b1;
        step(1);                  // now in WR_PL
        cfg_valid = 1'b0;
        stop_req  = 1'b1;         // leaves a pending stop behind
        step(1);                  // now in WR_PH
        stop_req  = 1'b0;
        n_checks++; if ({chipselect, write_n, address} !== {1'b1, 1'b0, 3'd3}) $display("FAIL rmid_in_wr_ph: got cs=%b wn=%b a=%h want 1/0/3", chipselect, write_n, address); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if ({chipselect, busy} !== 2'b00) $display("FAIL rmid_abort: got cs=%b busy=%b want 0/0", chipselect, busy); else n_pass++;
        n_checks++; if (cfg_ready !== 1'b1) $display("FAIL rmid_flags: got cfg_ready=%b want 1", cfg_ready); else n_pass++;
        step(2);
        reset_n = 1'b1;
        clear_logs();
        step(8);
        n_checks++; if (alog.size() !== 0) $display("FAIL rmid_no_replay: got %0d accesses want 0", alog.size()); else n_pass++;
    endtask

`ifdef TIMER_MASTER_READBACK_EN
    task automatic test_readback();
        clear_logs();
        corrupt = 1'b1;
        cfg_valid = 1'b1; cfg_period = 32'h0005_5555; cfg_continuous = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        step(10);
        n_checks++; if (wlog.size() !== 2 || alog.size() !== 4) $display("FAIL rb_bad_access: got w=%0d all=%0d want 2/4", wlog.size(), alog.size()); else n_pass++;
        n_checks++; if (cfg_error !== 1'b1) $display("FAIL rb_bad_error: got %h want 1", cfg_error); else n_pass++;
        clear_logs();
        corrupt = 1'b0;
        cfg_valid = 1'b1; cfg_period = 32'h0000_00FF; cfg_continuous = 1'b0;
        step(1);
        cfg_valid = 1'b0;
        n_checks++; if (cfg_error !== 1'b0) $display("FAIL rb_clear_error: got %h want 0", cfg_error); else n_pass++;
        step(10);
        n_checks++; if (wlog.size() !== 3) $display("FAIL rb_good_nwrites: got %0d want 3", wlog.size()); else n_pass++;
        if (wlog.size() == 3) begin
            n_checks++; if ({wlog[2].a, wlog[2].d} !== {3'd1, 16'h0005}) $display("FAIL rb_good_ctrl: got %h/%h want 1/0005", wlog[2].a, wlog[2].d); else n_pass++;
        end
        n_checks++; if (cfg_error !== 1'b0) $display("FAIL rb_good_error: got %h want 0", cfg_error); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_configure();
        test_timeout();
        test_snapshot();
        test_back_to_back();
        test_priority();
        test_reset_mid();
`ifdef TIMER_MASTER_READBACK_EN
        test_readback();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_timer_master

`default_nettype wire
